mem_responder: RTL and testbench

//  Memory-side responder for the multicycle CPU's instruction/data port. Accepts one

---
 rtl/mem_responder_pkg.sv | 15 +
 rtl/mem_responder_ram.sv | 26 ++
 rtl/mem_responder.sv | 145 ++++++++++++++
 tb/tb_mem_responder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: request size codes and FSM state encoding.
package mem_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/mem_responder_ram.sv
// Word-organised storage with per-byte write enables and an asynchronous word read.
module mem_responder_ram #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: one request in flight, registered response with error flag.
// Handshakes: a request transfers on an edge where req_valid && req_ready; a response transfers on an edge where resp_valid && resp_ready.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept, commit, req_err, ram_we;
  logic [3:0]  be;
  logic [31:0] wdata_lanes, ram_rdata, rd_shift, rd_val;

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dbg_state  = state_q;

  assign accept = req_valid && req_ready;
  // The last WAIT cycle is the commit cycle: its closing edge enters RESP.
  assign commit = (state_q == ST_WAIT) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WAIT;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit) begin
        rdata_q <= (req_err || we_q) ? 32'd0 : rd_val;
        err_q   <= req_err;
      end
    end
  end

  // Request fields need no reset: they are only consumed after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_comb begin
    req_err = 1'b0;
    if (size_q == SZ_RSVD)                          req_err = 1'b1;
    if (size_q == SZ_HALF && addr_q[0])             req_err = 1'b1;
    if (size_q == SZ_WORD && addr_q[1:0] != 2'b00)  req_err = 1'b1;
    if (addr_q[31:2] >= 30'(DEPTH_WORDS))           req_err = 1'b1;
  end

  always_comb begin
    be          = 4'b0000;
    wdata_lanes = wdata_q;
    case (size_q)
      SZ_BYTE: begin
        be          = 4'b0001 << addr_q[1:0];
        wdata_lanes = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        be          = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata_q[15:0]}};
      end
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Reset in the commit cycle suppresses the write.
  assign ram_we = commit && we_q && !req_err && reset;

  mem_responder_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .be   (be),
    .addr (addr_q[AW+1:2]),
    .wdata(wdata_lanes),
    .rdata(ram_rdata)
  );

  assign rd_shift = ram_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (size_q)
      SZ_BYTE: rd_val = {24'd0, rd_shift[7:0]};
      SZ_HALF: rd_val = {16'd0, rd_shift[15:0]};
      default: rd_val = ram_rdata;
    endcase
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: the same directed sequence runs on a LATENCY=2 and a LATENCY=1 instance.
module tb_mem_responder;
  import mem_responder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        req_valid [2];
  logic        req_we    [2];
  logic [1:0]  req_size  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        resp_ready[2];
  logic        req_ready [2];
  logic        resp_valid[2];
  logic [31:0] resp_rdata[2];
  logic        resp_err  [2];
  logic [1:0]  dbg_state [2];

  mem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut_l2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .dbg_state(dbg_state[0])
  );

  mem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .dbg_state(dbg_state[1])
  );

  int sel = 0;
  int lat = 2;
  // {check_rdata, err, rdata}
  logic [33:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s (dut latency %0d): got %08h expected %08h at %0t", name, lat, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (resp_valid[sel] === 1'b1 && resp_ready[sel] === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("resp_err", {31'd0, resp_err[sel]}, {31'd0, e[32]});
        if (e[33]) check("resp_rdata", resp_rdata[sel], e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready",  {31'd0, req_ready[sel]},  32'd1);
    check("rst_resp_valid", {31'd0, resp_valid[sel]}, 32'd0);
    check("rst_resp_rdata", resp_rdata[sel],          32'd0);
    check("rst_resp_err",   {31'd0, resp_err[sel]},   32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic wait_ready(output bit ok);
    int t;
    t = 0;
    @(negedge clk);
    while (req_ready[sel] !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    ok = (req_ready[sel] === 1'b1);
    if (!ok) check("req_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic we, input logic [1:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata);
    @(posedge clk); #1;
    req_valid[sel] = 1'b1;
    req_we[sel]    = we;
    req_size[sel]  = size;
    req_addr[sel]  = addr;
    req_wdata[sel] = wdata;
    @(posedge clk); #1;
    req_valid[sel] = 1'b0;
    req_we[sel]    = 1'($urandom_range(0, 1));
    req_size[sel]  = 2'($urandom_range(0, 3));
    req_addr[sel]  = $urandom;
    req_wdata[sel] = $urandom;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic exp_err,
                       input logic [31:0] exp_rdata, input int stall);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    exp_q.push_back({~we, exp_err, exp_rdata});
    send(we, size, addr, wdata);
    @(negedge clk);
    check("busy_req_ready", {31'd0, req_ready[sel]}, 32'd0);
    for (int k = 0; k < lat; k++) begin
      check("latency_low", {31'd0, resp_valid[sel]}, 32'd0);
      @(negedge clk);
    end
    check("latency_high", {31'd0, resp_valid[sel]}, 32'd1);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      req_valid[sel] = (s == 1);
      req_we[sel]    = 1'b1;
      req_size[sel]  = SZ_WORD;
      req_addr[sel]  = 32'h0;
      req_wdata[sel] = 32'hFFFF_FFFF;
      @(negedge clk);
      check("stall_resp_valid", {31'd0, resp_valid[sel]}, 32'd1);
      check("stall_req_ready",  {31'd0, req_ready[sel]},  32'd0);
      if (!we) check("stall_rdata", resp_rdata[sel], exp_rdata);
    end
    @(posedge clk); #1;
    req_valid[sel]  = 1'b0;
    resp_ready[sel] = 1'b1;
    @(posedge clk); #1;
    resp_ready[sel] = 1'b0;
    @(negedge clk);
    check("post_req_ready",  {31'd0, req_ready[sel]},  32'd1);
    check("post_resp_valid", {31'd0, resp_valid[sel]}, 32'd0);
  endtask

  // Write accepted, then reset lands on the next edge: mid-WAIT for LATENCY=2, commit edge for LATENCY=1.
  task automatic reset_mid(input logic [31:0] addr, input logic [31:0] wdata);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    send(1'b1, SZ_WORD, addr, wdata);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rstmid_resp_valid", {31'd0, resp_valid[sel]}, 32'd0);
      check("rstmid_req_ready",  {31'd0, req_ready[sel]},  32'd1);
    end
  endtask

  task automatic run_sequence();
    do_reset();
    issue(1'b1, SZ_WORD, 32'h00, 32'h1122_3344, 1'b0, 32'h0, 0);
    issue(1'b1, SZ_WORD, 32'h20, 32'hCAFE_F00D, 1'b0, 32'h0, 0);
    issue(1'b1, SZ_WORD, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 0);
    issue(1'b0, SZ_WORD, 32'h10, 32'h0,         1'b0, 32'hDEAD_BEEF, 0);
    // byte write with junk above bit 7; little-endian half @0x12 is bytes 0x13:0x12
    issue(1'b1, SZ_BYTE, 32'h13, 32'h1234_56AA, 1'b0, 32'h0, 0);
    issue(1'b0, SZ_HALF, 32'h12, 32'h0,         1'b0, 32'h0000_AAAD, 0);
    issue(1'b0, SZ_BYTE, 32'h11, 32'h0,         1'b0, 32'h0000_00BE, 0);
    issue(1'b0, SZ_WORD, 32'h10, 32'h0,         1'b0, 32'hAAAD_BEEF, 0);
    // error cases
    issue(1'b0, SZ_WORD, 32'h02,        32'h0,         1'b1, 32'h0, 0);
    issue(1'b1, SZ_HALF, 32'h01,        32'h0000_FFFF, 1'b1, 32'h0, 0);
    issue(1'b1, SZ_RSVD, 32'h00,        32'hFFFF_FFFF, 1'b1, 32'h0, 0);
    issue(1'b0, SZ_WORD, 32'h100,       32'h0,         1'b1, 32'h0, 0);
    issue(1'b1, SZ_WORD, 32'h8000_0010, 32'h0BAD_0BAD, 1'b1, 32'h0, 0);
    issue(1'b0, SZ_WORD, 32'h00,        32'h0,         1'b0, 32'h1122_3344, 0);
    issue(1'b0, SZ_WORD, 32'h10,        32'h0,         1'b0, 32'hAAAD_BEEF, 0);
    // upper half write and readback
    issue(1'b1, SZ_HALF, 32'h02, 32'hABCD_5566, 1'b0, 32'h0, 0);
    issue(1'b0, SZ_WORD, 32'h00, 32'h0,         1'b0, 32'h5566_3344, 0);
    // stall with a stray request pulse, which must not write word 0
    issue(1'b0, SZ_HALF, 32'h10, 32'h0, 1'b0, 32'h0000_BEEF, 5);
    issue(1'b0, SZ_WORD, 32'h00, 32'h0, 1'b0, 32'h5566_3344, 0);
    // reset mid-transaction
    reset_mid(32'h20, 32'h1234_5678);
    issue(1'b0, SZ_WORD, 32'h20, 32'h0, 1'b0, 32'hCAFE_F00D, 0);
    repeat (2) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- main ----------------
  initial begin
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i]  = 1'b0;
      req_we[i]     = 1'b0;
      req_size[i]   = SZ_WORD;
      req_addr[i]   = 32'h0;
      req_wdata[i]  = 32'h0;
      resp_ready[i] = 1'b0;
    end
    sel = 0; lat = 2;
    run_sequence();
    sel = 1; lat = 1;
    run_sequence();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
